// File: rtl/ones_counter_seq.sv
// Sequential ones counter: accepts a WIDTH-bit word, counts BITS_PER_CYCLE bits per clock,
// returns count plus zero/full flags. Define ONES_TOTAL_EN to add the saturating out_total port.
module ones_counter_seq #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  localparam int CW            = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic             out_full
`ifdef ONES_TOTAL_EN
  ,
  output logic [15:0]      out_total
`endif
);

  localparam int NCH = (BITS_PER_CYCLE > 0) ? (WIDTH / BITS_PER_CYCLE) : 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("ones_counter_seq: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [CHW-1:0]   r_chunk;
  logic [CW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic             r_zero;
  logic             r_full;
  logic [CW-1:0]    w_chunk_pop;
  logic [CW-1:0]    w_acc_sum;
  logic             w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = COUNT;
      COUNT:   if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Popcount of the chunk currently sitting in the low bits of the shift register.
  always_comb begin
    w_chunk_pop = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_chunk_pop = w_chunk_pop + CW'(r_shift[i]);
    end
  end

  assign w_acc_sum = r_acc + w_chunk_pop;
  assign w_last    = (r_chunk == CHW'(NCH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_chunk <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_zero  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= in_data;
            r_acc   <= '0;
            r_chunk <= '0;
          end
        end
        COUNT: begin
          r_shift <= r_shift >> BITS_PER_CYCLE;
          r_acc   <= w_acc_sum;
          r_chunk <= r_chunk + CHW'(1);
          // Result registers only change on the final chunk, so they hold through DONE.
          if (w_last) begin
            r_count <= w_acc_sum;
            r_zero  <= (w_acc_sum == '0);
            r_full  <= (w_acc_sum == CW'(WIDTH));
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_count = r_count;
  assign out_zero  = r_zero;
  assign out_full  = r_full;

`ifdef ONES_TOTAL_EN
  logic [15:0] r_total;
  logic [16:0] w_total_sum;

  assign w_total_sum = {1'b0, r_total} + 17'(r_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= '0;
    end else if (out_valid && out_ready) begin
      r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
    end
  end

  assign out_total = r_total;
`endif

endmodule

// File: tb/tb_ones_counter_seq.sv
// Directed bench for ones_counter_seq: a WIDTH=8/BPC=1 instance and a WIDTH=8/BPC=4 instance
// share data/out_ready; each has its own in_valid. Total checks run when ONES_TOTAL_EN is set.
module tb_ones_counter_seq;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       a_in_ready, b_in_ready;
  logic       a_out_valid, b_out_valid;
  logic [3:0] a_count, b_count;
  logic       a_zero, b_zero, a_full, b_full;
`ifdef ONES_TOTAL_EN
  logic [15:0] a_total, b_total;
`endif

  int checks = 0;
  int errors = 0;
  bit sel_b  = 1'b0;

  logic       m_in_ready, m_out_valid, m_zero, m_full;
  logic [3:0] m_count;

  ones_counter_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_count(a_count), .out_zero(a_zero), .out_full(a_full)
`ifdef ONES_TOTAL_EN
    , .out_total(a_total)
`endif
  );

  ones_counter_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_count(b_count), .out_zero(b_zero), .out_full(b_full)
`ifdef ONES_TOTAL_EN
    , .out_total(b_total)
`endif
  );

  always_comb begin
    m_in_ready  = sel_b ? b_in_ready  : a_in_ready;
    m_out_valid = sel_b ? b_out_valid : a_out_valid;
    m_count     = sel_b ? b_count     : a_count;
    m_zero      = sel_b ? b_zero      : a_zero;
    m_full      = sel_b ? b_full      : a_full;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic set_valid(input bit v);
    if (sel_b) b_valid = v;
    else       a_valid = v;
  endtask

  // One word through the selected instance; hold = cycles of backpressure once out_valid rises.
  task automatic run_word(input bit sel, input logic [7:0] d, input int exp_lat,
                          input int ec, input int ez, input int ef, input int hold);
    int lat;
    logic [3:0] cnt_seen;
    sel_b = sel;
    @(negedge clk);
    chk("ready_before_accept", int'(m_in_ready), 1);
    set_valid(1'b1);
    in_data   = d;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_valid(1'b0);
    in_data = ~d;
    lat = 0;
    while (!m_out_valid && lat < 40) begin
      chk("ready_low_busy", int'(m_in_ready), 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, exp_lat);
    chk("count", int'(m_count), ec);
    chk("zero", int'(m_zero), ez);
    chk("full", int'(m_full), ef);
    chk("ready_low_done", int'(m_in_ready), 0);
    $display("word %02h inst %0d latency %0d count %0d zero %0d full %0d",
             d, sel, lat, m_count, m_zero, m_full);
    cnt_seen = m_count;
    for (int h = 0; h < hold; h++) begin
      set_valid(1'b1);
      in_data = 8'h00;
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", int'(m_out_valid), 1);
      chk("bp_count", int'(m_count), int'(cnt_seen));
      chk("bp_zero", int'(m_zero), ez);
      chk("bp_full", int'(m_full), ef);
      chk("bp_ready", int'(m_in_ready), 0);
    end
    set_valid(1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", int'(m_out_valid), 0);
    chk("ready_back", int'(m_in_ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    int         c;
    int         z;
    int         f;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'b1011_0010, 4, 0, 0};
    vecs[1] = '{8'h00, 0, 1, 0};
    vecs[2] = '{8'hFF, 8, 0, 1};
    vecs[3] = '{8'h80, 1, 0, 0};
    vecs[4] = '{8'h01, 1, 0, 0};
    vecs[5] = '{8'h7F, 7, 0, 0};
    vecs[6] = '{8'hAA, 4, 0, 0};
    vecs[7] = '{8'h3C, 4, 0, 0};

    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", int'(a_in_ready), 1);
    chk("rst_valid", int'(a_out_valid), 0);
    chk("rst_count", int'(a_count), 0);
    chk("rst_zero", int'(a_zero), 0);
    chk("rst_full", int'(a_full), 0);
`ifdef ONES_TOTAL_EN
    chk("rst_total", int'(a_total), 0);
`endif

    // Back-to-back words on the bit-serial instance.
    for (int i = 0; i < 8; i++) begin
      run_word(1'b0, vecs[i].d, 8, vecs[i].c, vecs[i].z, vecs[i].f, 0);
    end

    // Four bits per cycle.
    run_word(1'b1, 8'hA5, 2, 4, 0, 0, 0);
    run_word(1'b1, 8'hFF, 2, 8, 0, 1, 0);
    run_word(1'b1, 8'h00, 2, 0, 1, 0, 0);

    // Backpressure for 10 cycles while in_valid is also pushed; the stray valids must be ignored.
    run_word(1'b0, 8'h3C, 8, 4, 0, 0, 10);
    run_word(1'b0, 8'hE0, 8, 3, 0, 0, 0);

    // Reset on the 3rd COUNT cycle discards the word.
    sel_b = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", int'(a_in_ready), 1);
    chk("midrst_valid", int'(a_out_valid), 0);
    chk("midrst_count", int'(a_count), 0);
    chk("midrst_zero", int'(a_zero), 0);
    chk("midrst_full", int'(a_full), 0);
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (a_out_valid) seen++;
      end
      chk("midrst_no_valid", seen, 0);
    end
    $display("reset mid-count: word discarded");
    run_word(1'b0, 8'h0F, 8, 4, 0, 0, 0);

    // rst together with in_valid: reset wins.
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0;
    chk("rstvalid_ready", int'(a_in_ready), 1);
    begin
      int seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (a_out_valid || !a_in_ready) seen++;
      end
      chk("rstvalid_not_accepted", seen, 0);
    end
    $display("reset with in_valid: word not accepted");

`ifdef ONES_TOTAL_EN
    do_reset();
    run_word(1'b0, 8'hFF, 8, 8, 0, 1, 0);
    chk("total_8", int'(a_total), 8);
    run_word(1'b0, 8'h03, 8, 2, 0, 0, 0);
    chk("total_10", int'(a_total), 10);
    run_word(1'b0, 8'h01, 8, 1, 0, 0, 0);
    chk("total_11", int'(a_total), 11);
    $display("total sequence %0d", a_total);

    do_reset();
    chk("total_cleared", int'(b_total), 0);
    out_ready = 1'b1;
    for (int w = 0; w < 8200; w++) begin
      @(negedge clk);
      b_valid = 1'b1; in_data = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      b_valid = 1'b0;
      repeat (3) @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("total_saturate", int'(b_total), 65535);
    $display("total after 8200 full words %0d", b_total);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_counter_seq.md
Name: ones_counter_seq

Overview:
- Sequential, parametrised successor to the 3-bit combinational ones counter (OC1).
- Accepts a WIDTH-bit word over a valid/ready handshake and counts its set bits, BITS_PER_CYCLE bits per clock.
- Returns the count plus all-zero and all-one flags over a second valid/ready handshake.
- Sits between a word producer and a consumer; one word is in flight at a time.

Parameters:
- WIDTH, 8, input word width; >= 2.
- BITS_PER_CYCLE, 1, bits examined per COUNT cycle; must divide WIDTH exactly (elaboration error otherwise).
- CW, $clog2(WIDTH+1), count width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to count.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CW  number of ones in the accepted word.
- out_zero  out  1  high when out_count == 0.
- out_full  out  1  high when out_count == WIDTH.
- out_total  out  16  running total; present only with ONES_TOTAL_EN.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst. Reset is sampled on the clk rising edge only.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_count=0, out_zero=0, out_full=0, internal shift register=0, chunk counter=0, out_total=0.
- FSM states: IDLE, COUNT, DONE. NCH = WIDTH/BITS_PER_CYCLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load shift register with in_data, clear accumulator, clear chunk counter, go to COUNT.
- COUNT:
  - in_ready=0.
  - Each cycle: add popcount of the low BITS_PER_CYCLE bits of the shift register to the accumulator, shift right by BITS_PER_CYCLE, increment the chunk counter.
  - When the chunk counter == NCH-1, go to DONE in the same edge.
- DONE:
  - out_valid=1; out_count, out_zero and out_full are registered and stable until handshake.
  - On out_ready: go to IDLE; out_valid drops on the next edge.
  - in_ready=0 in DONE, so no overlap with the next word.
- Latency: out_valid rises exactly NCH cycles after the input-handshake edge. Independent of data value; no early termination.
- Throughput: one word per NCH+2 cycles when out_ready is held high.
- Arithmetic:
  - The accumulator is CW bits and cannot overflow, since the maximum is WIDTH.
  - The per-chunk popcount is zero-extended to CW bits.
- Handshake rules:
  - in_data is sampled only on the accept edge; later changes are ignored.
  - out_* holds while out_valid&&!out_ready (backpressure indefinitely).
  - in_valid while in_ready=0 is ignored and has no effect.
- Boundaries:
  - in_data all zeros -> out_count=0, out_zero=1, out_full=0.
  - in_data all ones -> out_count=WIDTH, out_full=1.
  - BITS_PER_CYCLE=WIDTH -> NCH=1, so the result is valid 1 cycle after accept.
  - rst in any state, including mid-COUNT or DONE with out_valid high: the next edge forces reset values; the partial result is discarded without being emitted.
  - rst and in_valid asserted together: reset wins; the word is not accepted.

Optional Feature:
- Macro: ONES_TOTAL_EN.
- Defined:
  - out_total port exists.
  - On each output handshake (out_valid&&out_ready), out_total += out_count.
  - Saturates at 16'hFFFF; does not wrap.
  - Cleared only by rst.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, BPC=1:
  - Reset, then send 8'b1011_0010 with out_ready=1 -> out_valid 8 cycles after accept, out_count=4, out_zero=0, out_full=0.
  - Send 8'h00, then 8'hFF back to back -> counts 0 (out_zero=1), then 8 (out_full=1).
  - In_ready low from accept until the DONE handshake.
- WIDTH=8, BPC=4: send 8'hA5 -> out_valid 2 cycles after accept, out_count=4.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Outputs stay constant and in_ready stays 0.
  - Raise out_ready -> IDLE next cycle; in_ready=1.
- Reset mid-COUNT: accept 8'hFF, assert rst on the 3rd COUNT cycle.
  - Next edge: all outputs at reset values and out_valid never rises.
  - A following word 8'h0F yields 4.
- ONES_TOTAL_EN:
  - Words 8'hFF, 8'h03, 8'h01 -> out_total 8, 10, 11.
  - Preload via 8200 words of 8'hFF -> out_total saturates at 65535.
